// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO result registers
module muldiv_unit (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        divzero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b10;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;
    // sreg: bits consumed one per cycle (multiplier LSB-first, dividend MSB-first)
    // oper: stationary operand (multiplicand or divisor)
    logic [31:0] sreg_q, sreg_d;
    logic [31:0] oper_q, oper_d;
    logic [63:0] acc_q, acc_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] a_orig_q, a_orig_d;
    logic        bzero_q, bzero_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        divzero_q, divzero_d;

    logic        signed_op;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] mul_sum;
    logic [32:0] rem_shift;
    logic [32:0] trial;
    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        sreg_d    = sreg_q;
        oper_d    = oper_q;
        acc_d     = acc_q;
        count_d   = count_q;
        a_orig_d  = a_orig_q;
        bzero_d   = bzero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        divzero_d = divzero_q;
        done_d    = 1'b0;

        signed_op = ~op[0];
        mag_a     = (signed_op && A[31]) ? (32'd0 - A) : A;
        mag_b     = (signed_op && B[31]) ? (32'd0 - B) : B;

        mul_sum   = {1'b0, acc_q[63:32]} + (sreg_q[0] ? {1'b0, oper_q} : 33'd0);
        rem_shift = {acc_q[63:32], sreg_q[31]};
        trial     = rem_shift - {1'b0, oper_q};

        prod = (op_q == OP_MULT && (sa_q ^ sb_q)) ? (64'd0 - acc_q) : acc_q;
        quot = (op_q == OP_DIV && (sa_q ^ sb_q)) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        rem  = (op_q == OP_DIV && sa_q) ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d      = op;
                    sa_d      = signed_op & A[31];
                    sb_d      = signed_op & B[31];
                    sreg_d    = op[1] ? mag_a : mag_b;
                    oper_d    = op[1] ? mag_b : mag_a;
                    acc_d     = 64'd0;
                    count_d   = 5'd0;
                    a_orig_d  = A;
                    bzero_d   = (B == 32'd0);
                    divzero_d = 1'b0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    if (op_q[1]) begin
                        // restoring step: keep the trial result only when it did not go negative
                        if (!trial[32]) begin
                            acc_d = {trial[31:0], acc_q[30:0], 1'b1};
                        end else begin
                            acc_d = {rem_shift[31:0], acc_q[30:0], 1'b0};
                        end
                        sreg_d = {sreg_q[30:0], 1'b0};
                    end else begin
                        acc_d  = {mul_sum, acc_q[31:1]};
                        sreg_d = {1'b0, sreg_q[31:1]};
                    end
                    if (count_q == 5'd31) begin
                        state_d = S_FIX;
                    end else begin
                        count_d = count_q + 5'd1;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (!op_q[1]) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end else if (bzero_q) begin
                        hi_d      = a_orig_q;
                        lo_d      = 32'hFFFF_FFFF;
                        divzero_d = 1'b1;
                    end else begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= S_IDLE;
            op_q      <= 2'd0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            sreg_q    <= 32'd0;
            oper_q    <= 32'd0;
            acc_q     <= 64'd0;
            count_q   <= 5'd0;
            a_orig_q  <= 32'd0;
            bzero_q   <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            sreg_q    <= sreg_d;
            oper_q    <= oper_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            a_orig_q  <= a_orig_d;
            bzero_q   <= bzero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign divzero = divzero_q;

endmodule
